// File: rtl/twos_to_signmag_conv.sv
// Streaming two's-complement to sign-magnitude encoder with a two-stage valid/ready
// pipeline. The single unrepresentable code (-2^(D-1)) saturates to the largest negative magnitude.
module twos_to_signmag_conv #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [2*WIDTH-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     sat_cnt
);

  localparam int unsigned D = 2 * WIDTH;

  localparam logic [D-1:0]     MinCode = {1'b1, {(D-1){1'b0}}};
  localparam logic [D-1:0]     OneD    = {{(D-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stage 1 state
  logic         s1_valid_q;
  logic [D-1:0] s1_data_q;
  logic         s1_neg_q;
  logic         s1_min_q;

  // Stage 2 state (drives the outputs directly)
  logic         s2_valid_q;
  logic [D-1:0] s2_data_q;
  logic         s2_sat_q;

  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  logic         s1_load;
  logic         s2_load;
  logic [D-1:0] enc_data;
  logic [D-1:0] neg_data;
  logic         out_xfer;

  // S2 frees up when empty or draining; S1 may refill whenever S2 takes its word.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign out_xfer = s2_valid_q && out_ready;

  // Encoder, evaluated on the S1 contents.
  always_comb begin
    neg_data = ~s1_data_q + OneD;
    enc_data = {1'b0, s1_data_q[D-2:0]};
    if (s1_min_q) begin
      enc_data = {1'b1, {(D-1){1'b1}}};
    end else if (s1_neg_q) begin
      enc_data = {1'b1, neg_data[D-2:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_neg_q   <= 1'b0;
      s1_min_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= in_data;
        s1_neg_q  <= in_data[D-1];
        s1_min_q  <= (in_data == MinCode);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= enc_data;
        s2_sat_q  <= s1_min_q;
      end
    end
  end

  // Clear has priority over a coincident saturated transfer; the count sticks at max.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clear) begin
      sat_cnt_d = '0;
    end else if (out_xfer && s2_sat_q && (sat_cnt_q != CntMax)) begin
      sat_cnt_d = sat_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sat   = s2_sat_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_twos_to_signmag_conv.sv
// Directed bench for twos_to_signmag_conv (WIDTH=9, CNT_W=4): encoding, saturation,
// backpressure ordering, counter saturation/clear and mid-stream reset.
module tb_twos_to_signmag_conv;

  localparam int unsigned WIDTH = 9;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned D     = 2 * WIDTH;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic [D-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [D-1:0]     out_data;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] sat_cnt;

  int errors = 0;
  int checks = 0;

  twos_to_signmag_conv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [D-1:0] vin  [6];
  logic [D-1:0] vexp [6];
  logic         vsat [6];
  int           cnt_model;
  int           sent;
  int           rcv;
  logic         held_v;
  logic [D-1:0] held;
  logic         acc_in;

  initial begin
    vin  = '{18'h00005, 18'h3FFFB, 18'h00000, 18'h1FFFF, 18'h20000, 18'h3FFFF};
    vexp = '{18'h00005, 18'h20005, 18'h00000, 18'h1FFFF, 18'h3FFFF, 18'h20001};
    vsat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset held with in_valid high
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 18'h00005;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Basic encoding and saturation, streaming with out_ready=1
    cnt_model = 0;
    for (int i = 0; i <= 6; i++) begin
      in_valid = (i < 6);
      in_data  = (i < 6) ? vin[i] : '0;
      step();
      if (i == 0) begin
        chk("lat_out_valid_low", 32'(out_valid), 32'd0);
      end else begin
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_data", 32'(out_data), 32'(vexp[i-1]));
        chk("basic_sat", 32'(out_sat), 32'(vsat[i-1]));
      end
      chk("basic_sat_cnt", 32'(sat_cnt), 32'(cnt_model));
      if (i >= 1 && vsat[i-1]) cnt_model++;
    end
    in_valid = 1'b0;
    step();
    chk("basic_drained", 32'(out_valid), 32'd0);
    chk("basic_sat_cnt_final", 32'(sat_cnt), 32'd1);

    // Backpressure: 0..9 with a 5-cycle stall then random out_ready
    sent   = 0;
    rcv    = 0;
    held_v = 1'b0;
    held   = '0;
    for (int cyc = 0; cyc < 300 && rcv < 10; cyc++) begin
      out_ready = (cyc < 5) ? 1'b0 : ($urandom_range(0, 1) == 1);
      in_valid  = (sent < 10);
      in_data   = D'(sent);
      #1;
      if (held_v) chk("bp_stall_hold", 32'(out_data), 32'(held));
      if (cyc == 4) begin
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_buffered_valid", 32'(out_valid), 32'd1);
      end
      acc_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("bp_order", 32'(out_data), 32'(rcv));
        rcv++;
        held_v = 1'b0;
      end else begin
        held_v = out_valid;
        held   = out_data;
      end
      if (acc_in) sent++;
      @(posedge clk);
      #1;
    end
    chk("bp_count", 32'(rcv), 32'd10);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Counter saturation at 2^CNT_W-1
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 18'h20000;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("cnt_hold_max", 32'(sat_cnt), 32'd15);

    // Clear coincident with a saturated transfer
    in_valid = 1'b1;
    in_data  = 18'h20000;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_sat_present", 32'(out_valid && out_sat), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_wins", 32'(sat_cnt), 32'd0);
    step();
    chk("clr_stays", 32'(sat_cnt), 32'd0);

    // Reset with two words in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 18'h00011;
    step();
    in_data = 18'h00022;
    step();
    in_valid = 1'b0;
    chk("mid_inflight", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_ghost", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1;
    in_data  = 18'h3FFF9;
    step();
    in_valid = 1'b0;
    step();
    chk("mid_recover_valid", 32'(out_valid), 32'd1);
    chk("mid_recover_data", 32'(out_data), 32'h20007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
